// File: rtl/menu_select_controller.sv
// menu_select_controller
//   Front-end control for the main-menu renderer. Synchronises and debounces
//   the five board pushbuttons, tracks the highlighted menu option, and steps
//   the screen sequence MENU -> LAUNCH -> GAME / SCORES.
//   Outputs:
//     metadata  [28:26] option code, [25:24] screen code, [23:0] zero
//     start_game  one-cycle launch pulse
//     game_mode   mode latched at launch
//   Optional build macro MENU_WRAP_EN: when defined, up/down navigation wraps
//   within a column. When undefined, top/bottom moves hold position.
module menu_select_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        key_up_n,
  input  logic        key_down_n,
  input  logic        key_left_n,
  input  logic        key_right_n,
  input  logic        key_select_n,
  input  logic        game_over,
  output logic [28:0] metadata,
  output logic        start_game,
  output logic [1:0]  game_mode
);

  typedef enum logic [1:0] {
    S_MENU   = 2'd0,
    S_LAUNCH = 2'd1,
    S_GAME   = 2'd2,
    S_SCORES = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_SELECT = 3'd1,
    EV_UP     = 3'd2,
    EV_DOWN   = 3'd3,
    EV_LEFT   = 3'd4,
    EV_RIGHT  = 3'd5
  } event_e;

  // Key vector order: {select, up, down, left, right}.
  localparam int unsigned K_SELECT = 4;
  localparam int unsigned K_UP     = 3;
  localparam int unsigned K_DOWN   = 2;
  localparam int unsigned K_LEFT   = 1;
  localparam int unsigned K_RIGHT  = 0;

  localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

  logic [4:0]  raw_n;
  logic [4:0]  sync1_q, sync2_q;
  logic [4:0]  pressed;
  logic [19:0] cnt_q, cnt_d;
  logic        tick;
  logic [4:0]  sample_q;
  logic        primed_q;
  logic [4:0]  rise;
  event_e      ev;

  state_e      state_q, state_d;
  logic [2:0]  option_q, option_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  screen_q, screen_d;
  logic        start_q, start_d;

  assign raw_n   = {key_select_n, key_up_n, key_down_n, key_left_n, key_right_n};
  assign pressed = ~sync2_q;

  // Two-flop synchroniser for the asynchronous raw buttons.
  // NOTE: every flop resets here, including the synchroniser, so that a
  // button held through reset still looks released until it is really sampled.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      // NOTE: non-blocking assignments so both stages see pre-edge values.
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
    end
  end

  // Free-running sample counter; the wrap cycle is the sample tick.
  assign tick  = (cnt_q == CNT_MAX);
  assign cnt_d = tick ? 20'd0 : cnt_q + 20'd1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= 20'd0;
    else         cnt_q <= cnt_d;
  end

  // Latch the debounced key levels on every tick. The first tick after reset
  // only primes the samples, so a key held through reset must be released
  // and pressed again before it counts.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sample_q <= '0;
      primed_q <= 1'b0;
    end else if (tick) begin
      sample_q <= pressed;
      primed_q <= 1'b1;
    end
  end

  // Press events: sample 0->1 on a primed tick, reduced to the single
  // highest-priority key (select > up > down > left > right).
  assign rise = (tick && primed_q) ? (pressed & ~sample_q) : 5'd0;

  always_comb begin
    // NOTE: default first so every path assigns ev and no latch is inferred.
    ev = EV_NONE;
    if      (rise[K_SELECT]) ev = EV_SELECT;
    else if (rise[K_UP])     ev = EV_UP;
    else if (rise[K_DOWN])   ev = EV_DOWN;
    else if (rise[K_LEFT])   ev = EV_LEFT;
    else if (rise[K_RIGHT])  ev = EV_RIGHT;
  end

  // Menu grid: left column 0..2 (Play 1P, Endless, Play 2P),
  // right column 3..4 (Top 1P, Top Endless).
  function automatic logic [2:0] nav(input logic [2:0] opt, input event_e e);
    logic [2:0] n;
    n = opt;
    unique case (opt)
      3'd0: begin
`ifdef MENU_WRAP_EN
        if (e == EV_UP) n = 3'd2;
`endif
        if (e == EV_DOWN)  n = 3'd1;
        if (e == EV_RIGHT) n = 3'd3;
      end
      3'd1: begin
        if (e == EV_UP)    n = 3'd0;
        if (e == EV_DOWN)  n = 3'd2;
        if (e == EV_RIGHT) n = 3'd4;
      end
      3'd2: begin
        if (e == EV_UP)    n = 3'd1;
`ifdef MENU_WRAP_EN
        if (e == EV_DOWN)  n = 3'd0;
`endif
        if (e == EV_RIGHT) n = 3'd4;
      end
      3'd3: begin
`ifdef MENU_WRAP_EN
        if (e == EV_UP)    n = 3'd4;
`endif
        if (e == EV_DOWN)  n = 3'd4;
        if (e == EV_LEFT)  n = 3'd0;
      end
      3'd4: begin
        if (e == EV_UP)    n = 3'd3;
`ifdef MENU_WRAP_EN
        if (e == EV_DOWN)  n = 3'd3;
`endif
        if (e == EV_LEFT)  n = 3'd1;
      end
      default: n = opt;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] screen_of(input state_e s);
    logic [1:0] c;
    unique case (s)
      S_MENU:   c = 2'd0;
      S_LAUNCH: c = 2'd1;
      S_GAME:   c = 2'd1;
      S_SCORES: c = 2'd2;
      default:  c = 2'd0;
    endcase
    return c;
  endfunction

  // Screen sequencing, option navigation and launch decisions.
  always_comb begin
    state_d  = state_q;
    option_d = option_q;
    mode_d   = mode_q;
    unique case (state_q)
      S_MENU: begin
        if (ev == EV_SELECT) begin
          if (option_q <= 3'd2) begin
            state_d = S_LAUNCH;
            // Mode is captured on entry to LAUNCH so it is already valid
            // while start_game is high.
            mode_d  = option_q[1:0];
          end else begin
            state_d = S_SCORES;
          end
        end else if (ev != EV_NONE) begin
          option_d = nav(option_q, ev);
        end
      end
      S_LAUNCH: state_d = S_GAME;
      S_GAME:   if (game_over) state_d = S_MENU;
      S_SCORES: if (ev == EV_SELECT || ev == EV_LEFT) state_d = S_MENU;
      default:  state_d = S_MENU;
    endcase
    start_d  = (state_d == S_LAUNCH);
    screen_d = screen_of(state_d);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_MENU;
      option_q <= 3'd0;
      mode_q   <= 2'd0;
      screen_q <= 2'd0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      option_q <= option_d;
      mode_q   <= mode_d;
      screen_q <= screen_d;
      start_q  <= start_d;
    end
  end

  assign metadata   = {option_q, screen_q, 24'd0};
  assign start_game = start_q;
  assign game_mode  = mode_q;

endmodule

// File: doc/menu_select_controller.md
Name: menu_select_controller

Overview:
Upstream control stage for the main-menu renderer. Debounces the board pushbuttons, tracks the highlighted menu option, and sequences menu -> game / top-score screens. Produces the 29-bit metadata word consumed by the menu pixel processor, using the [28:26] option code, plus a one-cycle game-start pulse and mode code for the game core.

Parameters:
DEBOUNCE_CYCLES, 500000, clock cycles between button samples (10 ms at 50 MHz); legal range 2..1048575.

Ports:
clock  input  1  system clock (50 MHz)
resetn  input  1  asynchronous active-low reset
key_up_n  input  1  raw up button, active-low, asynchronous to clock
key_down_n  input  1  raw down button, active-low
key_left_n  input  1  raw left button, active-low
key_right_n  input  1  raw right button, active-low
key_select_n  input  1  raw select button, active-low
game_over  input  1  one-cycle pulse from game core when the game ends
metadata  output  29  [28:26] option code, [25:24] screen code, [23:0] zero
start_game  output  1  one-cycle pulse that launches a game
game_mode  output  2  latched mode: 0 Play 1P, 1 Endless, 2 Play 2P

Behaviour:
- Reset (resetn low, asynchronous): option=0, state MENU, metadata=29'd0, start_game=0, game_mode=0, sample counter=0, all sync/sample flops=released (1 on raw side, 0 pressed).
- Input path: each key goes through a 2-flop synchroniser, then is inverted to active-high.
- Sample counter: 20-bit; counts 0..DEBOUNCE_CYCLES-1, wraps to 0. On the wrap cycle (the sample tick) each synchronised key is latched into a sample register. A press event is the sample transition 0->1; exactly one event per press, none on release or hold.
- Simultaneous events in one tick: only the highest priority is acted on: select > up > down > left > right. The others are discarded.
- Option codes: 0 Play 1P, 1 Endless, 2 Play 2P (left column, rows 0-2); 3 Top 1P, 4 Top Endless (right column, rows 0-1). Codes 5-7 never occur.
- Navigation applies only in MENU (code: up / down / left / right):
  0: 0/1/0/3
  1: 0/2/1/4
  2: 1/2/2/4
  3: 3/4/0/3
  4: 3/4/1/4
- State machine, screen code in metadata[25:24]:
  MENU (0): nav events update option. Select with option 0-2 -> LAUNCH. Select with option 3 or 4 -> SCORES.
  LAUNCH (1): exactly one cycle. start_game=1, game_mode<=option[1:0], then -> GAME.
  GAME (1): all key events ignored. On game_over -> MENU, with option unchanged.
  SCORES (2): select or left event -> MENU, option unchanged. Other events are ignored.
- game_over outside GAME is ignored.
- Latency:
  - Option and screen updates are registered. metadata changes on the clock edge after the sample tick that carries the event.
  - start_game asserts the cycle after the LAUNCH transition edge (one-cycle registered pulse).
  - All outputs are registered. There is no combinational path from inputs to outputs.
- A press held across a reset is not a new event after reset until it is released and pressed again. Sample registers reset to "pressed" only if the key is still low at the first tick; the sampled value then must see 0 first.

Optional Feature:
MENU_WRAP_EN
- Defined: vertical navigation wraps within a column:
  - 0 up -> 2, 2 down -> 0
  - 3 up -> 4, 4 down -> 3
  - All other entries are as in the table.
- Undefined: no wrap; the table above is exact and top/bottom moves hold position.

Test Plan:
1. DEBOUNCE_CYCLES=4, reset, release all keys -> metadata=0, start_game=0 on every cycle.
2. Press down, hold 20 cycles, release; repeat once -> metadata[28:26] goes 0->1->2, one step per press, no repeat while held.
3. From option 2 press right, then up -> option 4 then 3. Press left -> option 0. Then press up without MENU_WRAP_EN -> stays 0; with MENU_WRAP_EN -> 2.
4. Option 1, press select -> start_game high exactly 1 cycle, game_mode=1, metadata[25:24]=1. Presses during GAME do not change metadata. Pulse game_over -> metadata[25:24]=0, [28:26]=1.
5. Option 3, press select -> metadata[25:24]=2. Press down -> no change. Press left -> back to MENU with option 3.
6. Press select and down in the same sample window at option 0 -> LAUNCH with game_mode=0, option stays 0. Assert resetn low mid-GAME -> all outputs 0 immediately, without waiting for a clock edge.
